// File: rtl/alu_seq_flags.sv
// Registered WIDTH-bit ALU with NZCV flags, valid/ready on both sides
// and a shift-add multiplier that takes one bit of b per cycle.
module alu_seq_flags #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                 en_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [SW-1:0]        cnt;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   acc_nx;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SW-1:0]        sh;
  logic [2*WIDTH-1:0]   shl_w;
  logic [2*WIDTH-1:0]   shr_w;
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c;
  logic                 alu_v;

  // en_q keeps in_ready low until the first clock after reset release
  assign in_ready  = en_q & (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL_RUN);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (sel == 3'b111);
  assign mul_last  = (cnt == SW'(WIDTH - 1));
  assign acc_nx    = acc + (mplier[0] ? mcand : '0);

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign sh    = b[SW-1:0];
  assign shl_w = {{WIDTH{1'b0}}, a} << sh;
  assign shr_w = {a, {WIDTH{1'b0}}} >> sh;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      (sel == 3'b000): begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);
      end
      (sel == 3'b001): begin
        alu_r = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                (diff[WIDTH-1] != a[WIDTH-1]);
      end
      (sel == 3'b010): alu_r = a & b;
      (sel == 3'b011): alu_r = a | b;
      (sel == 3'b100): alu_r = a ^ b;
      (sel == 3'b101): begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      (sel == 3'b110): begin
        alu_r = shr_w[2*WIDTH-1:WIDTH];
        alu_c = shr_w[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = is_mul ? MUL_RUN : DONE;
      MUL_RUN: if (mul_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
    end else begin
      state <= state_nx;
      en_q  <= 1'b1;
      if (state == IDLE && accept) begin
        if (is_mul) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt    <= '0;
        end else begin
          result <= alu_r;
          n      <= alu_r[WIDTH-1];
          z      <= (alu_r == '0);
          c      <= alu_c;
          v      <= alu_v;
        end
      end
      if (state == MUL_RUN) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result <= acc_nx[WIDTH-1:0];
          n      <= acc_nx[WIDTH-1];
          z      <= (acc_nx[WIDTH-1:0] == '0);
          c      <= |acc_nx[2*WIDTH-1:WIDTH];
          v      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Bench for alu_seq_flags: directed and random ops, scoreboard
// checked by an independent monitor against an arithmetic model.
module tb_alu_seq_flags;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       n, z, c, v, busy;

  alu_seq_flags #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .n(n), .z(z), .c(c), .v(v),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] exp;
    int          lat;
    int          acc;
  } item_t;

  item_t sbq[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    seen = 1'b0;
  bit    rnd_bp = 1'b0;
  bit    ready_cmd = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    out_ready = rnd_bp ? (($urandom % 3) != 0) : ready_cmd;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {res,n,z,c,v}
  function automatic logic [11:0] model(input int s, input int x,
                                        input int y);
    int r, cf, vf, sx, sy, t, sh;
    sh = y % 8;
    sx = (x >= 128) ? x - 256 : x;
    sy = (y >= 128) ? y - 256 : y;
    r = 0; cf = 0; vf = 0;
    case (s)
      0: begin
        t = x + y; r = t % 256; cf = int'(t > 255);
        vf = int'((sx + sy > 127) || (sx + sy < -128));
      end
      1: begin
        r = (x - y + 256) % 256; cf = int'(x >= y);
        vf = int'((sx - sy > 127) || (sx - sy < -128));
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin
        r = (x * (1 << sh)) % 256;
        cf = (sh == 0) ? 0 : ((x >> (8 - sh)) & 1);
      end
      6: begin
        r = x / (1 << sh);
        cf = (sh == 0) ? 0 : ((x >> (sh - 1)) & 1);
      end
      default: begin
        t = x * y; r = t % 256; cf = int'(t > 255);
      end
    endcase
    model = {8'(r), r >= 128, r == 0, cf[0], vf[0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        chk("result_nzcv", {20'd0, result, n, z, c, v}, sbq[0].exp);
        if (!seen)
          chk("latency", cyc - sbq[0].acc + 1, sbq[0].lat);
        seen = 1'b1;
        if (out_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int s, input int x, input int y);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    sel = 3'(s);
    a = 8'(x);
    b = 8'(y);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{exp: model(s, x, y),
                        lat: (s == 7) ? 9 : 1, acc: cyc + 1});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    sel = 3'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {result, n, z, c, v, out_valid, busy, in_ready},
        32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    issue(0, 8'h7F, 8'h01);
    issue(1, 8'h05, 8'h05);
    issue(1, 8'h03, 8'h05);
    issue(5, 8'h81, 8'h01);
    issue(6, 8'h81, 8'h00);
    issue(5, 8'h81, 8'h08);
    issue(6, 8'h81, 8'h0F);
    drain();
    issue(7, 8'h10, 8'h10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_mul", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    issue(7, 8'h0F, 8'h03);
    issue(7, 8'hFF, 8'hFF);
    drain();

    ready_cmd = 1'b0;
    @(posedge clk);
    #3;
    issue(4, 8'hF0, 8'hFF);
    in_valid = 1'b1;
    sel = 3'd0;
    a = 8'h01;
    b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    ready_cmd = 1'b1;
    issue(0, 8'h01, 8'h01);
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++)
      issue($urandom_range(0, 7), $urandom_range(0, 255),
            $urandom_range(0, 255));
    drain();
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(7, 8'h37, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {result, n, z, c, v, out_valid, busy, in_ready},
        32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_abort", {31'd0, in_ready}, 32'd1);
    issue(0, 8'h01, 8'h01);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
